// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between an RV32I
// pipeline and a word-wide data memory.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we, req_funct3    store flag and RV32I width/sign code
//   req_addr, req_wdata   byte address, right-aligned store data
//   dm_cs, dm_bweb        memory select and active-high byte write enables
//   dm_addr, dm_wdata     word address and lane-replicated store data
//   dm_ack, dm_rdata      memory completion and read word (same cycle)
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  extended load result and error flag
//   stall                 pipeline hold request
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        dm_cs,
    output logic [3:0]  dm_bweb,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        dm_cs_q, dm_cs_d;
    logic [3:0]  dm_bweb_q, dm_bweb_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    // Request legality: alignment plus the funct3 codes each direction allows.
    // Stores have no unsigned variants, so any funct3[2]=1 store is illegal.
    logic req_legal;
    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: req_legal = 1'b1;
            3'b001, 3'b101: req_legal = ~req_addr[0];
            3'b010:         req_legal = (req_addr[1:0] == 2'b00);
            default:        req_legal = 1'b0;
        endcase
        if (req_we && req_funct3[2]) req_legal = 1'b0;
    end

    // Store lane steering: data replicated across lanes, enables pick the lane.
    logic [3:0]  st_bweb;
    logic [31:0] st_wdata;
    always_comb begin
        st_bweb  = 4'b1111;
        st_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                st_bweb  = 4'b0001 << req_addr[1:0];
                st_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_bweb  = req_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                st_bweb  = 4'b1111;
                st_wdata = req_wdata;
            end
        endcase
    end

    // Load extraction from the latched byte offset.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    always_comb begin
        ld_byte = dm_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dm_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        dm_cs_d      = dm_cs_q;
        dm_bweb_d    = dm_bweb_q;
        dm_addr_d    = dm_addr_q;
        dm_wdata_d   = dm_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    if (req_legal) begin
                        state_d    = S_ACCESS;
                        cnt_d      = 8'd1;
                        dm_cs_d    = 1'b1;
                        dm_bweb_d  = req_we ? st_bweb : 4'b0000;
                        dm_addr_d  = {req_addr[31:2], 2'b00};
                        dm_wdata_d = st_wdata;
                    end else begin
                        // Rejected without touching memory.
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end
                end
            end
            S_ACCESS: begin
                // Ack is checked first so an ack on the final cycle beats the timeout.
                if (dm_ack) begin
                    state_d      = S_RESP;
                    cnt_d        = 8'd0;
                    dm_cs_d      = 1'b0;
                    dm_bweb_d    = 4'b0000;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = we_q ? 32'd0 : ld_data;
                end else if (cnt_q == TIMEOUT_LIM) begin
                    state_d      = S_RESP;
                    cnt_d        = 8'd0;
                    dm_cs_d      = 1'b0;
                    dm_bweb_d    = 4'b0000;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                dm_cs_d   = 1'b0;
                dm_bweb_d = 4'b0000;
                cnt_d     = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            dm_cs_q      <= 1'b0;
            dm_bweb_q    <= 4'b0000;
            dm_addr_q    <= 32'd0;
            dm_wdata_q   <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            dm_cs_q      <= dm_cs_d;
            dm_bweb_q    <= dm_bweb_d;
            dm_addr_q    <= dm_addr_d;
            dm_wdata_q   <= dm_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign stall      = (state_q == S_ACCESS) || ((state_q == S_IDLE) && req_valid);
    assign dm_cs      = dm_cs_q;
    assign dm_bweb    = dm_bweb_q;
    assign dm_addr    = dm_addr_q;
    assign dm_wdata   = dm_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed scenarios plus random transactions
// checked against a transaction-level reference model.
module tb_lsu_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        dm_cs;
    logic [3:0]  dm_bweb;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] last_rdata = 32'd0;

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .dm_cs(dm_cs), .dm_bweb(dm_bweb), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .stall(stall)
    );

    always #5 clk = ~clk;

    // One complete transaction. ack_dly = idle ACCESS cycles before dm_ack;
    // ack_dly >= TO means memory never answers. noise drives dm_ack in
    // IDLE/RESP cycles, where it must have no effect.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int ack_dly,
                           input logic noise, input string tag);
        logic        legal, tmo, exp_err;
        logic [1:0]  off;
        logic [3:0]  exp_bweb;
        logic [31:0] exp_wd, exp_res, exp_rdata, bytev, halfv;
        bit          done;
        int          w;
        // ---- reference model ----
        off = addr[1:0];
        if (we) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) legal = 1'b0;
        if (f3 == 3'd2 && off != 2'd0) legal = 1'b0;
        bytev = (rd >> (8 * off)) & 32'hFF;
        halfv = (rd >> (8 * (off & 2'd2))) & 32'hFFFF;
        case (f3)
            3'd0:    exp_res = (bytev >= 128)   ? bytev + 32'hFFFF_FF00 : bytev;
            3'd4:    exp_res = bytev;
            3'd1:    exp_res = (halfv >= 32768) ? halfv + 32'hFFFF_0000 : halfv;
            3'd5:    exp_res = halfv;
            default: exp_res = rd;
        endcase
        case (f3)
            3'd0:    begin exp_bweb = 4'(1 << off);                  exp_wd = (wd & 32'hFF) * 32'h0101_0101; end
            3'd1:    begin exp_bweb = (off >= 2) ? 4'hC : 4'h3;     exp_wd = (wd & 32'hFFFF) * 32'h0001_0001; end
            default: begin exp_bweb = 4'hF;                         exp_wd = wd; end
        endcase
        if (!we) exp_bweb = 4'h0;
        tmo       = (ack_dly >= TO);
        exp_err   = !legal || tmo;
        exp_rdata = (exp_err || we) ? 32'd0 : exp_res;

        // ---- request cycle (IDLE) ----
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        dm_ack = noise; dm_rdata = $urandom;
        #1;
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s idle req_ready got %b exp 1", tag, req_ready); end
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL %s idle stall got %b exp 1", tag, stall); end
        n_chk++; if (resp_valid !== 1'b0 || dm_cs !== 1'b0) begin n_fail++; $display("FAIL %s idle resp_valid/dm_cs got %b/%b exp 0/0", tag, resp_valid, dm_cs); end
        n_chk++; if (resp_rdata !== last_rdata) begin n_fail++; $display("FAIL %s rdata_hold got %h exp %h", tag, resp_rdata, last_rdata); end

        @(negedge clk);
        req_valid = 1'b0; req_we = $urandom; req_funct3 = $urandom; req_addr = $urandom; req_wdata = $urandom;
        if (legal) begin
            done = 0; w = 0;
            while (!done) begin
                if (w == ack_dly) begin dm_ack = 1'b1; dm_rdata = rd; end
                else begin dm_ack = 1'b0; dm_rdata = $urandom; end
                #1;
                n_chk++; if (dm_cs !== 1'b1 || stall !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
                    n_fail++; $display("FAIL %s access_ctl cyc %0d cs/stall/ready/rv got %b%b%b%b exp 1100", tag, w + 1, dm_cs, stall, req_ready, resp_valid); end
                n_chk++; if (dm_addr !== {addr[31:2], 2'b00}) begin n_fail++; $display("FAIL %s dm_addr got %h exp %h", tag, dm_addr, {addr[31:2], 2'b00}); end
                n_chk++; if (dm_bweb !== exp_bweb) begin n_fail++; $display("FAIL %s dm_bweb got %b exp %b", tag, dm_bweb, exp_bweb); end
                if (we) begin
                    n_chk++; if (dm_wdata !== exp_wd) begin n_fail++; $display("FAIL %s dm_wdata got %h exp %h", tag, dm_wdata, exp_wd); end
                end
                if (w == ack_dly || w + 1 == TO) done = 1;
                w++;
                @(negedge clk);
            end
        end
        // ---- RESP cycle ----
        dm_ack = noise; dm_rdata = $urandom;
        #1;
        n_chk++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL %s resp_valid got %b exp 1", tag, resp_valid); end
        n_chk++; if (resp_err !== exp_err) begin n_fail++; $display("FAIL %s resp_err got %b exp %b", tag, resp_err, exp_err); end
        n_chk++; if (resp_rdata !== exp_rdata) begin n_fail++; $display("FAIL %s resp_rdata got %h exp %h", tag, resp_rdata, exp_rdata); end
        n_chk++; if (dm_cs !== 1'b0 || dm_bweb !== 4'h0 || stall !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s resp_ctl cs/bweb/stall/ready got %b/%b/%b/%b exp 0/0000/0/0", tag, dm_cs, dm_bweb, stall, req_ready); end
        last_rdata = exp_rdata;
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        req_valid = 1'b0; dm_ack = $urandom; dm_rdata = $urandom;
        #1;
        n_chk++; if (resp_valid !== 1'b0 || stall !== 1'b0 || dm_cs !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s idle rv/stall/cs/ready got %b%b%b%b exp 0001", tag, resp_valid, stall, dm_cs, req_ready); end
        n_chk++; if (resp_rdata !== last_rdata) begin n_fail++; $display("FAIL %s idle rdata_hold got %h exp %h", tag, resp_rdata, last_rdata); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; dm_ack = 1'b0; dm_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++; if (dm_cs !== 1'b0 || dm_bweb !== 4'h0 || dm_addr !== 32'd0 || dm_wdata !== 32'd0) begin
            n_fail++; $display("FAIL reset dm cs/bweb/addr/wdata got %b/%b/%h/%h exp 0", dm_cs, dm_bweb, dm_addr, dm_wdata); end
        n_chk++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset resp v/err/rdata got %b/%b/%h exp 0", resp_valid, resp_err, resp_rdata); end
        n_chk++; if (req_ready !== 1'b1 || stall !== 1'b0) begin
            n_fail++; $display("FAIL reset ready/stall got %b/%b exp 1/0", req_ready, stall); end
        rst_n = 1'b1;
        last_rdata = 32'd0;
    endtask

    task automatic test_directed;
        run_txn(1'b0, 3'd0, 32'h0000_1003, 32'd0,          32'h80FF_1234, 0, 1'b0, "lb_sext");
        run_txn(1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF,  32'h1111_2222, 0, 1'b0, "sh_upper");
        run_txn(1'b0, 3'd5, 32'h0000_4002, 32'd0,          32'h8001_7FFF, 3, 1'b0, "lhu_wait3");
        run_txn(1'b0, 3'd2, 32'h0000_3001, 32'd0,          32'h0,         0, 1'b0, "lw_misalign");
        run_txn(1'b1, 3'd0, 32'h0000_0011, 32'hCAFE_BA5A,  32'h0,         1, 1'b0, "sb_lane1");
        run_txn(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF,  32'h0,         0, 1'b0, "sw");
        run_txn(1'b1, 3'd4, 32'h0000_0100, 32'h1,          32'h0,         0, 1'b0, "store_bu_illegal");
        run_txn(1'b0, 3'd1, 32'h0000_0200, 32'd0,          32'h1234_8765, 0, 1'b0, "lh_sext_low");
    endtask

    task automatic test_timeout;
        run_txn(1'b0, 3'd2, 32'h0000_0400, 32'd0, 32'h5555_AAAA, 100,    1'b0, "timeout");
        run_txn(1'b0, 3'd2, 32'h0000_0404, 32'd0, 32'h5555_AAAA, TO - 1, 1'b0, "ack_on_last");
        run_txn(1'b1, 3'd2, 32'h0000_0408, 32'h7, 32'h0,         TO - 2, 1'b0, "ack_before_last");
    endtask

    task automatic test_back_to_back;
        run_txn(1'b0, 3'd4, 32'h0000_0803, 32'd0, 32'h8000_0000, 0, 1'b1, "b2b_lbu");
        run_txn(1'b0, 3'd7, 32'h0000_0800, 32'd0, 32'h0,         0, 1'b1, "b2b_illegal");
        run_txn(1'b0, 3'd2, 32'h0000_0800, 32'd0, 32'hA5A5_5A5A, 2, 1'b1, "b2b_lw");
        idle_cycle("b2b_after");
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0500; dm_ack = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        n_chk++; if (dm_cs !== 1'b1) begin n_fail++; $display("FAIL rst_mid in_access dm_cs got %b exp 1", dm_cs); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        #1;
        n_chk++; if (dm_cs !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0 || dm_bweb !== 4'h0 || dm_addr !== 32'd0) begin
            n_fail++; $display("FAIL rst_mid after cs/ready/stall/bweb/addr got %b/%b/%b/%b/%h exp 0/1/0/0000/0", dm_cs, req_ready, stall, dm_bweb, dm_addr); end
        n_chk++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
            n_fail++; $display("FAIL rst_mid resp v/err/rdata got %b/%b/%h exp 0", resp_valid, resp_err, resp_rdata); end
        last_rdata = 32'd0;
        @(negedge clk);
        dm_ack = 1'b0;
        #1;
        n_chk++; if (resp_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid late_ack rv/stall got %b/%b exp 0/0", resp_valid, stall); end
        req_valid = 1'b1;
        #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid stall_follows got %b exp 1", stall); end
        req_valid = 1'b0;
        #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid stall_drop got %b exp 0", stall); end
        repeat (2) idle_cycle("rst_mid_idle");
    endtask

    task automatic test_random;
        int r, dly;
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      dly = TO + 3;
            else if (r == 1) dly = TO - 1;
            else             dly = $urandom_range(0, 4);
            run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, dly, 1'($urandom), "rand");
            if ($urandom_range(0, 3) == 0) idle_cycle("rand_gap");
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_timeout;
        test_back_to_back;
        test_reset_mid_access;
        test_random;
        @(negedge clk);
        req_valid = 1'b0; dm_ack = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
